// File: rtl/score_scanner.sv
`timescale 1ns/1ps
// score_scanner
//
// Scans every cell of a GRID_W x GRID_H game board held in an external
// synchronous-read RAM and reports how many cells each of four players owns,
// which player leads, and whether that lead is shared.
//
// Ports
//   CLOCK_50             in   single clock, rising edge
//   resetn               in   asynchronous active-low reset
//   start                in   request one full scan (honoured in IDLE / DONE)
//   address[14:0]        out  RAM read address {x[7:0], y[6:0]}, registered
//   q[2:0]               in   RAM read data, valid one cycle after address
//   p1..p4_count[14:0]   out  cells owned by each player
//   winner[1:0]          out  leading player index (0 = p1 .. 3 = p4)
//   tie                  out  leading count shared by two or more players
//   busy                 out  scan in progress (CLEAR/SCAN/DRAIN/DECIDE)
//   done                 out  results valid and held
module score_scanner #(
    parameter int GRID_W = 160,
    parameter int GRID_H = 120
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    output logic [14:0] address,
    input  logic [2:0]  q,
    output logic [14:0] p1_count,
    output logic [14:0] p2_count,
    output logic [14:0] p3_count,
    output logic [14:0] p4_count,
    output logic [1:0]  winner,
    output logic        tie,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DRAIN,
        S_DECIDE,
        S_DONE
    } state_t;

    localparam logic [7:0] X_LAST = 8'(GRID_W - 1);
    localparam logic [6:0] Y_LAST = 7'(GRID_H - 1);

    state_t            state_q, state_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic              rvld_q, rvld_d;
    logic [3:0][14:0]  cnt_q, cnt_d;
    logic [1:0]        winner_q, winner_d;
    logic              tie_q, tie_d;

    logic [3:0]        hit;
    logic [2:0]        verdict;
    logic              last_cell;

    // Map a board colour to a one-hot player increment; unowned and
    // invalid colours produce no increment.
    function automatic logic [3:0] colour_hit(input logic [2:0] v);
        logic [3:0] h;
        case (v)
            3'b001:  h = 4'b0001;
            3'b010:  h = 4'b0010;
            3'b100:  h = 4'b0100;
            3'b110:  h = 4'b1000;
            default: h = 4'b0000;
        endcase
        return h;
    endfunction

    // Returns {winner, tie}. Strict '>' keeps the lowest index on equal counts.
    function automatic logic [2:0] pick_winner(input logic [3:0][14:0] c);
        logic [1:0] best;
        logic       shared;
        best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (c[i] > c[best]) begin
                best = 2'(i);
            end
        end
        shared = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((2'(i) != best) && (c[i] == c[best])) begin
                shared = 1'b1;
            end
        end
        return {best, shared};
    endfunction

    assign hit       = colour_hit(q);
    assign verdict   = pick_winner(cnt_q);
    assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

    // ---- next-state / datapath ----
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rvld_d   = 1'b0;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        tie_d    = tie_q;

        // rvld_q marks that q carries the cell addressed last cycle; it is
        // only ever set by SCAN, so this covers SCAN and the DRAIN tail.
        if (rvld_q) begin
            for (int i = 0; i < 4; i++) begin
                if (hit[i]) begin
                    cnt_d[i] = cnt_q[i] + 15'd1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d    = '0;
                winner_d = 2'd0;
                tie_d    = 1'b0;
                x_d      = 8'd0;
                y_d      = 7'd0;
                state_d  = S_SCAN;
            end
            S_SCAN: begin
                rvld_d = 1'b1;
                if (last_cell) begin
                    // Final address stays on the bus; its data lands in DRAIN.
                    state_d = S_DRAIN;
                end else if (y_q == Y_LAST) begin
                    x_d = x_q + 8'd1;
                    y_d = 7'd0;
                end else begin
                    y_d = y_q + 7'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                winner_d = verdict[2:1];
                tie_d    = verdict[0];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---- state registers ----
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            rvld_q   <= 1'b0;
            cnt_q    <= '0;
            winner_q <= 2'd0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rvld_q   <= rvld_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
        end
    end

    assign address  = {x_q, y_q};
    assign p1_count = cnt_q[0];
    assign p2_count = cnt_q[1];
    assign p3_count = cnt_q[2];
    assign p4_count = cnt_q[3];
    assign winner   = winner_q;
    assign tie      = tie_q;
    assign busy     = (state_q == S_CLEAR) || (state_q == S_SCAN) ||
                      (state_q == S_DRAIN) || (state_q == S_DECIDE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_score_scanner.sv
`timescale 1ns/1ps
// Bench for score_scanner: a reduced 40x30 instance carries most scenarios,
// a default-size instance covers one full 160x120 board.
module tb_score_scanner;

    localparam int SW = 40;
    localparam int SH = 30;
    localparam int BW = 160;
    localparam int BH = 120;

    logic        clk;
    logic        rstn;

    logic        start_s, start_b;
    logic [14:0] addr_s, addr_b;
    logic [2:0]  q_s, q_b;
    logic [14:0] p1_s, p2_s, p3_s, p4_s;
    logic [14:0] p1_b, p2_b, p3_b, p4_b;
    logic [1:0]  win_s, win_b;
    logic        tie_s, tie_b, busy_s, busy_b, done_s, done_b;

    logic [2:0]  mem_s [0:32767];
    logic [2:0]  mem_b [0:32767];
    logic [14:0] log_s [$];
    logic [14:0] log_b [$];

    typedef struct {
        int p1; int p2; int p3; int p4; int w; int t;
    } exp_t;
    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;

    score_scanner #(.GRID_W(SW), .GRID_H(SH)) dut_s (
        .CLOCK_50(clk), .resetn(rstn), .start(start_s), .address(addr_s), .q(q_s),
        .p1_count(p1_s), .p2_count(p2_s), .p3_count(p3_s), .p4_count(p4_s),
        .winner(win_s), .tie(tie_s), .busy(busy_s), .done(done_s)
    );

    score_scanner dut_b (
        .CLOCK_50(clk), .resetn(rstn), .start(start_b), .address(addr_b), .q(q_b),
        .p1_count(p1_b), .p2_count(p2_b), .p3_count(p3_b), .p4_count(p4_b),
        .winner(win_b), .tie(tie_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM models: data one cycle after address.
    always @(posedge clk) begin
        q_s <= mem_s[addr_s];
        q_b <= mem_b[addr_b];
    end

    // Record the address seen in every busy cycle.
    always @(negedge clk) begin
        if (busy_s) log_s.push_back(addr_s);
        if (busy_b) log_b.push_back(addr_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] pat_val(input int pat, input int x, input int y,
                                           input int w, input int h);
        case (pat)
            0: return 3'b000;
            1: return 3'b001;
            2: return (x < w / 4) ? 3'b010 : ((x < w / 2) ? 3'b100 : 3'b110);
            3: return (y == h - 1) ? 3'b111 : ((x < w / 2) ? 3'b100 : 3'b110);
            default: return 3'b010;
        endcase
    endfunction

    // Off-grid cells hold 001 so any stray read would inflate p1.
    task automatic fill(input bit big, input int pat);
        int w, h;
        logic [7:0] xa;
        logic [6:0] ya;
        w = big ? BW : SW;
        h = big ? BH : SH;
        for (int a = 0; a < 32768; a++) begin
            if (big) mem_b[a] = 3'b001; else mem_s[a] = 3'b001;
        end
        for (int x = 0; x < w; x++) begin
            for (int y = 0; y < h; y++) begin
                xa = 8'(x);
                ya = 7'(y);
                if (big) mem_b[{xa, ya}] = pat_val(pat, x, y, w, h);
                else     mem_s[{xa, ya}] = pat_val(pat, x, y, w, h);
            end
        end
    endtask

    task automatic push_exp(input int a, input int b, input int c, input int d,
                            input int w, input int t);
        exp_t e;
        e.p1 = a; e.p2 = b; e.p3 = c; e.p4 = d; e.w = w; e.t = t;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for done; lat = edges counted after the start edge, -1 on timeout.
    // poke > 0 raises start for one cycle at that edge count (while busy).
    task automatic wait_done(input bit big, input int budget, input int poke, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (poke > 0) begin
                if (big) start_b = (i == poke); else start_s = (i == poke);
            end
            if (big ? done_b : done_s) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic compare_results(input bit big, input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_p1"}, big ? p1_b : p1_s, e.p1);
            chk({tag, "_p2"}, big ? p2_b : p2_s, e.p2);
            chk({tag, "_p3"}, big ? p3_b : p3_s, e.p3);
            chk({tag, "_p4"}, big ? p4_b : p4_s, e.p4);
            chk({tag, "_winner"}, big ? win_b : win_s, e.w);
            chk({tag, "_tie"}, big ? tie_b : tie_s, e.t);
        end
    endtask

    // Busy-cycle address log: CLEAR (previous address), N scan addresses
    // with y inner / x outer, then the held last address in DRAIN and DECIDE.
    task automatic check_seq(input bit big, input string tag);
        logic [14:0] lg [$];
        int n, h, bad;
        logic [14:0] ea;
        h = big ? BH : SH;
        n = (big ? BW : SW) * h;
        if (big) lg = log_b; else lg = log_s;
        bad = 0;
        chk({tag, "_seq_len"}, lg.size(), n + 3);
        if (lg.size() == n + 3) begin
            for (int k = 0; k < n; k++) begin
                ea = {8'(k / h), 7'(k % h)};
                if (lg[k + 1] !== ea) bad++;
            end
            ea = {8'((n - 1) / h), 7'((n - 1) % h)};
            if (lg[n + 1] !== ea || lg[n + 2] !== ea) bad++;
        end
        chk({tag, "_seq"}, bad, 0);
    endtask

    task automatic run_scan(input bit big, input int poke, input string tag);
        int lat, n;
        n = big ? BW * BH : SW * SH;
        if (big) log_b.delete(); else log_s.delete();
        @(negedge clk);
        if (big) start_b = 1'b1; else start_s = 1'b1;
        @(posedge clk);
        #1;
        if (big) start_b = 1'b0; else start_s = 1'b0;
        wait_done(big, n + 40, poke, lat);
        chk({tag, "_latency"}, lat, n + 3);
        compare_results(big, tag);
        check_seq(big, tag);
    endtask

    initial begin
        int lat;
        rstn    = 1'b0;
        start_s = 1'b0;
        start_b = 1'b0;
        fill(1'b0, 0);
        fill(1'b1, 2);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", addr_s, 0);
        chk("rst_p1", p1_s, 0);
        chk("rst_p4", p4_s, 0);
        chk("rst_winner", win_s, 0);
        chk("rst_tie", tie_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_big_done", done_b, 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy_s, 0);
        chk("idle_done", done_s, 0);

        // Full default-size board: column bands of 010 / 100 / 110
        push_exp(0, 4800, 4800, 9600, 3, 0);
        run_scan(1'b1, -1, "big_cols");

        // All empty: every count equal, tie to player 1
        push_exp(0, 0, 0, 0, 0, 1);
        run_scan(1'b0, -1, "zero");

        // All player 1, with a start pulse mid-scan that must be ignored
        fill(1'b0, 1);
        push_exp(SW * SH, 0, 0, 0, 0, 0);
        run_scan(1'b0, 100, "p1_poke");
        repeat (4) @(negedge clk);
        chk("p1_hold_done", done_s, 1);
        chk("p1_hold_cnt", p1_s, SW * SH);
        chk("p1_hold_busy", busy_s, 0);

        // Column bands: 10 cols 010, 10 cols 100, 20 cols 110
        fill(1'b0, 2);
        push_exp(0, 300, 300, 600, 3, 0);
        run_scan(1'b0, -1, "cols");

        // p3/p4 halves with last row 111: equal counts, tie to p3
        fill(1'b0, 3);
        push_exp(0, 0, 580, 580, 2, 1);
        run_scan(1'b0, -1, "tie34");

        // Reset asserted mid-scan
        fill(1'b0, 1);
        log_s.delete();
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        repeat (501) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy_s, 1);
        chk("mid_p1_nonzero", (p1_s != 15'd0), 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_addr", addr_s, 0);
        chk("mid_rst_p1", p1_s, 0);
        chk("mid_rst_busy", busy_s, 0);
        chk("mid_rst_done", done_s, 0);
        chk("mid_rst_winner", win_s, 0);
        chk("mid_rst_tie", tie_s, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy_s, 0);
        fill(1'b0, 4);
        push_exp(0, SW * SH, 0, 0, 1, 0);
        run_scan(1'b0, -1, "after_rst");

        // start held high: scan, DONE for one cycle, then immediate re-scan
        fill(1'b0, 2);
        push_exp(0, 300, 300, 600, 3, 0);
        push_exp(0, 300, 300, 600, 3, 0);
        log_s.delete();
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1'b0, SW * SH + 40, -1, lat);
        chk("held1_latency", lat, SW * SH + 3);
        compare_results(1'b0, "held1");
        check_seq(1'b0, "held1");
        log_s.delete();
        wait_done(1'b0, SW * SH + 40, -1, lat);
        start_s = 1'b0;
        chk("held2_latency", lat, SW * SH + 4);
        compare_results(1'b0, "held2");
        check_seq(1'b0, "held2");
        repeat (3) @(negedge clk);
        chk("held_stay_done", done_s, 1);
        chk("held_stay_p4", p4_s, 600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
